// File: rtl/salu_arbiter.sv
// rtl/salu_arbiter.sv - round-robin arbiter/sequencer sharing one combinational salu among NUM_REQ requesters
// Optional grant lock FSM is compiled in when SALU_ARB_LOCK_EN is defined.
module salu_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_rs1_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_rs2_i,
  input  logic [NUM_REQ*4-1:0]          req_op_i,
  input  logic [NUM_REQ-1:0]            req_lock_i,
  output logic [NUM_REQ-1:0]            rsp_valid_o,
  input  logic [NUM_REQ-1:0]            rsp_ready_i,
  output logic [DATA_WIDTH-1:0]         rsp_data_o,
  output logic                          rsp_zero_o,
  output logic                          rsp_neg_o,
  output logic                          rsp_ovf_o,
  output logic [DATA_WIDTH-1:0]         alu_rs1_o,
  output logic [DATA_WIDTH-1:0]         alu_rs2_o,
  output logic [3:0]                    alu_op_o,
  input  logic [DATA_WIDTH-1:0]         alu_res_i,
  input  logic                          alu_zero_i,
  input  logic                          alu_neg_i,
  input  logic                          alu_ovf_i,
  output logic                          busy_o
);
  localparam int ID_WIDTH = $clog2(NUM_REQ);

  logic                  s1_valid_q, s1_valid_d;
  logic [ID_WIDTH-1:0]   s1_id_q, s1_id_d;
  logic [DATA_WIDTH-1:0] s1_rs1_q, s1_rs1_d, s1_rs2_q, s1_rs2_d;
  logic [3:0]            s1_op_q, s1_op_d;
  logic                  s2_valid_q, s2_valid_d;
  logic [ID_WIDTH-1:0]   s2_id_q, s2_id_d;
  logic [DATA_WIDTH-1:0] s2_data_q, s2_data_d;
  logic                  s2_zero_q, s2_zero_d, s2_neg_q, s2_neg_d, s2_ovf_q, s2_ovf_d;
  logic [ID_WIDTH-1:0]   ptr_q, ptr_d;

  logic [NUM_REQ-1:0]    eligible;
  logic                  ptr_frozen;
  logic                  grant_found;
  logic [ID_WIDTH-1:0]   grant_id;
  logic                  s2_free, s1_move, s1_can_accept, accept;

  assign s2_free       = s2_valid_q & rsp_ready_i[s2_id_q];
  assign s1_move       = s1_valid_q & (~s2_valid_q | s2_free);
  assign s1_can_accept = ~s1_valid_q | s1_move;
  assign accept        = grant_found & s1_can_accept & ~rst_i;

`ifdef SALU_ARB_LOCK_EN
  typedef enum logic {LK_IDLE, LK_LOCKED} lock_state_e;
  lock_state_e         lock_state_q, lock_state_d;
  logic [ID_WIDTH-1:0] owner_q, owner_d;

  // While locked only the owner competes and the round-robin pointer stays put.
  always_comb begin
    eligible = req_valid_i;
    if (lock_state_q == LK_LOCKED) begin
      eligible          = '0;
      eligible[owner_q] = req_valid_i[owner_q];
    end
  end
  assign ptr_frozen = (lock_state_q == LK_LOCKED);

  always_comb begin
    lock_state_d = lock_state_q;
    owner_d      = owner_q;
    case (lock_state_q)
      LK_IDLE: begin
        if (accept && req_lock_i[grant_id]) begin
          lock_state_d = LK_LOCKED;
          owner_d      = grant_id;
        end
      end
      LK_LOCKED: begin
        if (accept && !req_lock_i[grant_id]) lock_state_d = LK_IDLE;
      end
      default: lock_state_d = LK_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lock_state_q <= LK_IDLE;
      owner_q      <= '0;
    end else begin
      lock_state_q <= lock_state_d;
      owner_q      <= owner_d;
    end
  end
`else
  logic unused_lock;
  assign unused_lock = ^req_lock_i;
  assign eligible    = req_valid_i;
  assign ptr_frozen  = 1'b0;
`endif

  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      logic [ID_WIDTH-1:0] cand;
      cand = ID_WIDTH'((int'(ptr_q) + k) % NUM_REQ);
      if (!grant_found && eligible[cand]) begin
        grant_found = 1'b1;
        grant_id    = cand;
      end
    end
  end

  always_comb begin
    req_ready_o = '0;
    if (accept) req_ready_o[grant_id] = 1'b1;
    rsp_valid_o = '0;
    if (s2_valid_q) rsp_valid_o[s2_id_q] = 1'b1;
  end

  always_comb begin
    s1_valid_d = accept | (s1_valid_q & ~s1_move);
    s1_id_d    = s1_id_q;
    s1_rs1_d   = s1_rs1_q;
    s1_rs2_d   = s1_rs2_q;
    s1_op_d    = s1_op_q;
    if (accept) begin
      s1_id_d  = grant_id;
      s1_rs1_d = req_rs1_i[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
      s1_rs2_d = req_rs2_i[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
      s1_op_d  = req_op_i[int'(grant_id)*4 +: 4];
    end
    // S2 captures the salu outputs for whatever S1 is presenting this cycle.
    s2_valid_d = s1_move | (s2_valid_q & ~s2_free);
    s2_id_d    = s2_id_q;
    s2_data_d  = s2_data_q;
    s2_zero_d  = s2_zero_q;
    s2_neg_d   = s2_neg_q;
    s2_ovf_d   = s2_ovf_q;
    if (s1_move) begin
      s2_id_d   = s1_id_q;
      s2_data_d = alu_res_i;
      s2_zero_d = alu_zero_i;
      s2_neg_d  = alu_neg_i;
      s2_ovf_d  = alu_ovf_i;
    end
    ptr_d = ptr_q;
    if (accept && !ptr_frozen) ptr_d = (int'(grant_id) == NUM_REQ-1) ? '0 : grant_id + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid_q <= 1'b0;
      s1_id_q    <= '0;
      s1_rs1_q   <= '0;
      s1_rs2_q   <= '0;
      s1_op_q    <= '0;
      s2_valid_q <= 1'b0;
      s2_id_q    <= '0;
      s2_data_q  <= '0;
      s2_zero_q  <= 1'b0;
      s2_neg_q   <= 1'b0;
      s2_ovf_q   <= 1'b0;
      ptr_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_id_q    <= s1_id_d;
      s1_rs1_q   <= s1_rs1_d;
      s1_rs2_q   <= s1_rs2_d;
      s1_op_q    <= s1_op_d;
      s2_valid_q <= s2_valid_d;
      s2_id_q    <= s2_id_d;
      s2_data_q  <= s2_data_d;
      s2_zero_q  <= s2_zero_d;
      s2_neg_q   <= s2_neg_d;
      s2_ovf_q   <= s2_ovf_d;
      ptr_q      <= ptr_d;
    end
  end

  assign alu_rs1_o  = s1_rs1_q;
  assign alu_rs2_o  = s1_rs2_q;
  assign alu_op_o   = s1_op_q;
  assign rsp_data_o = s2_data_q;
  assign rsp_zero_o = s2_zero_q;
  assign rsp_neg_o  = s2_neg_q;
  assign rsp_ovf_o  = s2_ovf_q;
  assign busy_o     = s1_valid_q | s2_valid_q;
endmodule

// File: tb/tb_salu_arbiter.sv
// tb/tb_salu_arbiter.sv - randomized self-checking bench for salu_arbiter against a queue-level reference model
module tb_salu_arbiter;
  localparam int N = 4;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid_i, req_ready_o, req_lock_i, rsp_valid_o, rsp_ready_i;
  logic [N*W-1:0] req_rs1_i, req_rs2_i;
  logic [N*4-1:0] req_op_i;
  logic [W-1:0]   rsp_data_o, alu_rs1_o, alu_rs2_o, alu_res_i;
  logic           rsp_zero_o, rsp_neg_o, rsp_ovf_o, alu_zero_i, alu_neg_i, alu_ovf_i, busy_o;
  logic [3:0]     alu_op_o;

  salu_arbiter #(.NUM_REQ(N), .DATA_WIDTH(W)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_rs1_i(req_rs1_i), .req_rs2_i(req_rs2_i), .req_op_i(req_op_i), .req_lock_i(req_lock_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_data_o(rsp_data_o),
    .rsp_zero_o(rsp_zero_o), .rsp_neg_o(rsp_neg_o), .rsp_ovf_o(rsp_ovf_o),
    .alu_rs1_o(alu_rs1_o), .alu_rs2_o(alu_rs2_o), .alu_op_o(alu_op_o),
    .alu_res_i(alu_res_i), .alu_zero_i(alu_zero_i), .alu_neg_i(alu_neg_i), .alu_ovf_i(alu_ovf_i),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  // Stand-in for the shared salu: ADD, SUB, and an arbitrary mix for other codes.
  function automatic logic [W+2:0] alu_f(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] op);
    logic [W-1:0] r;
    logic         o;
    case (op)
      4'd0:    begin r = a + b; o = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]); end
      4'd1:    begin r = a - b; o = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]); end
      default: begin r = a ^ {b[W-5:0], op}; o = 1'b0; end
    endcase
    return {o, r[W-1], (r == '0), r};
  endfunction

  always_comb {alu_ovf_i, alu_neg_i, alu_zero_i, alu_res_i} = alu_f(alu_rs1_o, alu_rs2_o, alu_op_o);

  typedef struct { int id; logic [W-1:0] a; logic [W-1:0] b; logic [3:0] op; logic lock; } op_t;
  typedef struct { int id; logic [W-1:0] a; logic [W-1:0] b; logic [3:0] op; int acc; } fl_t;

  op_t          pend[$];
  fl_t          q[$];
  logic [W-1:0] rsp_log[$];
  int           checks = 0, failures = 0, cycle = 0, ptr = 0, owner = 0;
  bit           locked = 0;
  logic [N-1:0] rsp_rdy = '1;
  bit           m_fire, m_acc;
  int           m_g;
  logic [N-1:0] exp_ready, exp_rv;
  logic [W-1:0] exp_data;
  logic         exp_z, exp_n, exp_o, exp_busy;

  function automatic int head_of(input int id);
    for (int j = 0; j < pend.size(); j++) if (pend[j].id == id) return j;
    return -1;
  endfunction

  function automatic int pend_cnt(input int id);
    int c = 0;
    foreach (pend[j]) if (pend[j].id == id) c++;
    return c;
  endfunction

  function automatic int oh_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic push_op(input int id, input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] op, input logic lock);
    op_t e;
    e.id = id; e.a = a; e.b = b; e.op = op; e.lock = lock;
    pend.push_back(e);
  endtask

  task automatic drive();
    req_valid_i = '0; req_lock_i = '0; req_rs1_i = '0; req_rs2_i = '0; req_op_i = '0;
    for (int i = 0; i < N; i++) begin
      int h;
      h = head_of(i);
      if (h >= 0) begin
        req_valid_i[i]      = 1'b1;
        req_lock_i[i]       = pend[h].lock;
        req_rs1_i[i*W +: W] = pend[h].a;
        req_rs2_i[i*W +: W] = pend[h].b;
        req_op_i[i*4 +: 4]  = pend[h].op;
      end
    end
    rsp_ready_i = rsp_rdy;
  endtask

  // Predicts this cycle's outputs from the in-flight queue; an op is visible two cycles after acceptance.
  task automatic cyc_begin();
    drive();
    @(negedge clk);
    m_fire = 0; exp_rv = '0; exp_data = '0; exp_z = 0; exp_n = 0; exp_o = 0;
    if (q.size() > 0 && cycle >= q[0].acc + 2) begin
      exp_rv[q[0].id] = 1'b1;
      {exp_o, exp_n, exp_z, exp_data} = alu_f(q[0].a, q[0].b, q[0].op);
      m_fire = rsp_rdy[q[0].id];
    end
    m_g = -1;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (ptr + k) % N;
      if (m_g < 0 && head_of(i) >= 0 && (!locked || i == owner)) m_g = i;
    end
    m_acc = (m_g >= 0) && (q.size() < 2 || m_fire);
    exp_ready = '0;
    if (m_acc) exp_ready[m_g] = 1'b1;
    exp_busy = (q.size() > 0);
    if ((rsp_valid_o & rsp_ready_i) != '0) rsp_log.push_back(rsp_data_o);
  endtask

  task automatic cyc_end();
    @(posedge clk);
    if (m_fire) void'(q.pop_front());
    if (m_acc) begin
      int  h;
      fl_t e;
      h = head_of(m_g);
      e.id = m_g; e.a = pend[h].a; e.b = pend[h].b; e.op = pend[h].op; e.acc = cycle;
      q.push_back(e);
`ifdef SALU_ARB_LOCK_EN
      if (!locked) begin
        ptr = (m_g + 1) % N;
        if (pend[h].lock) begin locked = 1; owner = m_g; end
      end else if (!pend[h].lock) locked = 0;
`else
      ptr = (m_g + 1) % N;
`endif
      pend.delete(h);
    end
    cycle++;
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    drive();
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete(); ptr = 0; locked = 0; cycle++;
  endtask

  task automatic drain(input string name);
    rsp_rdy = '1;
    for (int k = 0; k < 200 && (q.size() > 0 || pend.size() > 0); k++) begin
      if (locked && head_of(owner) < 0) push_op(owner, 1, 1, 4'd0, 1'b0);
      cyc_begin();
      cyc_end();
    end
    checks++;
    if (busy_o !== 1'b0) begin
      failures++;
      $display("FAIL %s_drain busy_o: got %b required 0", name, busy_o);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < N; i++) push_op(i, 32'h11 * i, 32'h3, 4'd0, 1'b0);
    drive();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (req_ready_o !== '0) begin failures++; $display("FAIL reset_req_ready: got %b required 0000", req_ready_o); end
    checks++; if (rsp_valid_o !== '0) begin failures++; $display("FAIL reset_rsp_valid: got %b required 0000", rsp_valid_o); end
    checks++; if (rsp_data_o !== '0) begin failures++; $display("FAIL reset_rsp_data: got %h required 0", rsp_data_o); end
    checks++; if ({rsp_zero_o, rsp_neg_o, rsp_ovf_o} !== 3'b000) begin failures++; $display("FAIL reset_flags: got %b required 000", {rsp_zero_o, rsp_neg_o, rsp_ovf_o}); end
    checks++; if ({alu_rs1_o, alu_rs2_o, alu_op_o} !== '0) begin failures++; $display("FAIL reset_alu: got %h/%h/%h required 0", alu_rs1_o, alu_rs2_o, alu_op_o); end
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b required 0", busy_o); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    pend.delete(); q.delete(); ptr = 0; locked = 0; cycle++;
  endtask

  task automatic test_single_add();
    rsp_rdy = '1;
    push_op(0, 32'd5, 32'd7, 4'd0, 1'b0);
    cyc_begin();
    checks++; if (req_ready_o !== 4'b0001) begin failures++; $display("FAIL add_accept: got %b required 0001", req_ready_o); end
    cyc_end();
    cyc_begin();
    checks++; if (rsp_valid_o !== 4'b0000) begin failures++; $display("FAIL add_early_rsp: got %b required 0000", rsp_valid_o); end
    checks++; if (alu_rs1_o !== 32'd5 || alu_rs2_o !== 32'd7 || alu_op_o !== 4'd0) begin failures++; $display("FAIL add_alu_drive: got %0d,%0d,%0d required 5,7,0", alu_rs1_o, alu_rs2_o, alu_op_o); end
    cyc_end();
    cyc_begin();
    checks++; if (rsp_valid_o !== 4'b0001) begin failures++; $display("FAIL add_rsp_valid: got %b required 0001", rsp_valid_o); end
    checks++; if (rsp_data_o !== 32'd12 || rsp_zero_o !== 1'b0) begin failures++; $display("FAIL add_rsp_data: got %0d zero=%b required 12 zero=0", rsp_data_o, rsp_zero_o); end
    cyc_end();
    drain("single_add");
  endtask

  task automatic test_contention();
    int eg[5] = '{0, 1, 2, 3, 0};
    apply_reset();
    rsp_rdy = '1;
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++) push_op(i, $urandom, $urandom, 4'($urandom_range(0, 15)), 1'b0);
    for (int k = 0; k < 10; k++) begin
      cyc_begin();
      if (k < 5) begin
        checks++;
        if (oh_idx(req_ready_o) !== eg[k] || $countones(req_ready_o) != 1) begin
          failures++; $display("FAIL contention_grant[%0d]: got %b required requester %0d", k, req_ready_o, eg[k]);
        end
      end
      checks++;
      if (rsp_valid_o !== exp_rv) begin failures++; $display("FAIL contention_route[%0d]: got %b required %b", k, rsp_valid_o, exp_rv); end
      if (exp_rv != '0) begin
        checks++;
        if (rsp_data_o !== exp_data) begin failures++; $display("FAIL contention_data[%0d]: got %h required %h", k, rsp_data_o, exp_data); end
      end
      cyc_end();
    end
    drain("contention");
  endtask

  task automatic test_backpressure();
    apply_reset();
    rsp_rdy = 4'b1101;
    rsp_log.delete();
    push_op(1, 32'd3, 32'd3, 4'd1, 1'b0);
    push_op(1, 32'd1, 32'd1, 4'd0, 1'b0);
    push_op(1, 32'd9, 32'd4, 4'd1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      logic [N-1:0] er;
      er = (k < 2) ? 4'b0010 : 4'b0000;
      cyc_begin();
      checks++;
      if (req_ready_o !== er) begin failures++; $display("FAIL bp_ready[%0d]: got %b required %b", k, req_ready_o, er); end
      if (k >= 2) begin
        checks++;
        if (rsp_valid_o !== 4'b0010 || rsp_data_o !== '0 || rsp_zero_o !== 1'b1) begin
          failures++; $display("FAIL bp_hold[%0d]: got v=%b d=%h z=%b required v=0010 d=0 z=1", k, rsp_valid_o, rsp_data_o, rsp_zero_o);
        end
      end
      cyc_end();
    end
    rsp_rdy = '1;
    cyc_begin();
    checks++;
    if (req_ready_o !== 4'b0010 || rsp_valid_o !== 4'b0010) begin
      failures++; $display("FAIL bp_release: got ready=%b valid=%b required 0010/0010", req_ready_o, rsp_valid_o);
    end
    cyc_end();
    drain("backpressure");
    checks++;
    if (rsp_log.size() != 3 || rsp_log[0] !== 32'd0 || rsp_log[1] !== 32'd2 || rsp_log[2] !== 32'd5) begin
      failures++; $display("FAIL bp_order: got %0d responses required 3 (0,2,5)", rsp_log.size());
    end
  endtask

  task automatic test_overflow();
    bit got = 0;
    rsp_rdy = '1;
    push_op(3, 32'h7FFF_FFFF, 32'd1, 4'd0, 1'b0);
    for (int k = 0; k < 10 && !got; k++) begin
      cyc_begin();
      if (rsp_valid_o[3]) begin
        got = 1;
        checks++;
        if (rsp_data_o !== 32'h8000_0000 || rsp_ovf_o !== 1'b1 || rsp_neg_o !== 1'b1 || rsp_zero_o !== 1'b0) begin
          failures++; $display("FAIL ovf_result: got %h o=%b n=%b z=%b required 80000000 o=1 n=1 z=0", rsp_data_o, rsp_ovf_o, rsp_neg_o, rsp_zero_o);
        end
      end
      cyc_end();
    end
    checks++;
    if (!got) begin failures++; $display("FAIL ovf_timeout: got no response required one"); end
    drain("overflow");
  endtask

  task automatic test_lock();
    int eg[4];
    int gl[$];
`ifdef SALU_ARB_LOCK_EN
    eg = '{2, 2, 2, 0};
`else
    eg = '{2, 0, 2, 0};
`endif
    apply_reset();
    rsp_rdy = '1;
    push_op(1, 32'd1, 32'd2, 4'd0, 1'b0);
    cyc_begin();
    cyc_end();
    push_op(2, 32'd10, 32'd1, 4'd0, 1'b1);
    push_op(2, 32'd20, 32'd1, 4'd0, 1'b1);
    push_op(2, 32'd30, 32'd1, 4'd0, 1'b0);
    push_op(0, 32'd40, 32'd1, 4'd0, 1'b0);
    push_op(0, 32'd50, 32'd1, 4'd0, 1'b0);
    for (int k = 0; k < 16 && gl.size() < 4; k++) begin
      cyc_begin();
      if (req_ready_o != '0) gl.push_back(oh_idx(req_ready_o));
      cyc_end();
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (k >= gl.size()) begin failures++; $display("FAIL lock_grant[%0d]: got none required %0d", k, eg[k]); end
      else if (gl[k] != eg[k]) begin failures++; $display("FAIL lock_grant[%0d]: got %0d required %0d", k, gl[k], eg[k]); end
    end
    drain("lock");
  endtask

  task automatic test_reset_midop();
    bit got = 0;
    rsp_rdy = 4'b1011;
    push_op(2, 32'd8, 32'd8, 4'd0, 1'b0);
    for (int k = 0; k < 10 && !got; k++) begin
      cyc_begin();
      if (rsp_valid_o[2]) got = 1;
      cyc_end();
    end
    checks++;
    if (!got) begin failures++; $display("FAIL rstmid_setup: got no S2 response required one"); end
    apply_reset();
    rsp_rdy = '1;
    push_op(1, 32'd1, 32'd1, 4'd0, 1'b0);
    push_op(3, 32'd3, 32'd3, 4'd0, 1'b0);
    cyc_begin();
    checks++; if (rsp_valid_o !== '0) begin failures++; $display("FAIL rstmid_rsp_valid: got %b required 0000", rsp_valid_o); end
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL rstmid_busy: got %b required 0", busy_o); end
    checks++; if (req_ready_o !== 4'b0010) begin failures++; $display("FAIL rstmid_ptr: got %b required 0010", req_ready_o); end
    cyc_end();
    drain("reset_midop");
  endtask

  task automatic test_random();
    apply_reset();
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 1) == 0) begin
        int id;
        id = int'($urandom_range(0, N-1));
        if (pend_cnt(id) < 3)
          push_op(id, ($urandom_range(0, 3) == 0) ? 32'h7FFF_FFFF : $urandom, ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom,
                  ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 1)) : 4'($urandom_range(0, 15)), $urandom_range(0, 3) == 0);
      end
      for (int i = 0; i < N; i++) rsp_rdy[i] = ($urandom_range(0, 3) != 0);
      cyc_begin();
      checks++;
      if (req_ready_o !== exp_ready) begin failures++; $display("FAIL rand_ready@%0d: got %b required %b", cycle, req_ready_o, exp_ready); end
      checks++;
      if (rsp_valid_o !== exp_rv) begin failures++; $display("FAIL rand_rsp_valid@%0d: got %b required %b", cycle, rsp_valid_o, exp_rv); end
      if (exp_rv != '0) begin
        checks++;
        if ({rsp_ovf_o, rsp_neg_o, rsp_zero_o, rsp_data_o} !== {exp_o, exp_n, exp_z, exp_data}) begin
          failures++; $display("FAIL rand_rsp@%0d: got %b%b%b/%h required %b%b%b/%h", cycle, rsp_ovf_o, rsp_neg_o, rsp_zero_o, rsp_data_o, exp_o, exp_n, exp_z, exp_data);
        end
      end
      checks++;
      if (busy_o !== exp_busy) begin failures++; $display("FAIL rand_busy@%0d: got %b required %b", cycle, busy_o, exp_busy); end
      cyc_end();
    end
    drain("random");
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_single_add();
    test_contention();
    test_backpressure();
    test_overflow();
    test_lock();
    test_reset_midop();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/salu_arbiter.md
# salu_arbiter

Round-robin arbiter and sequencer that shares one combinational `salu` instance among `NUM_REQ` requesters, such as the scalar issue path, the vector-unit scalar-operand path and the address-generation helpers. It accepts operations over per-requester valid/ready handshakes and drives the external ALU from a registered operand stage. It captures ALU results and flags into a response register and returns them only to the originating requester, with full backpressure and no loss or duplication.

## Interface
- `NUM_REQ`, 4: number of requesters, ≥2.
- `DATA_WIDTH`, 32: operand/result width; must match the shared `salu`.
- `ID_WIDTH`, $clog2(NUM_REQ): derived localparam, not overridable.
- `clk_i` input 1: single clock; all state updates on rising edge.
- `rst_i` input 1: reset, synchronous, active-high.
- `req_valid_i` input NUM_REQ: per-requester operation valid.
- `req_ready_o` output NUM_REQ: per-requester accept; at most one bit set per cycle.
- `req_rs1_i` input NUM_REQ*DATA_WIDTH: packed rs1 operands; requester i uses slice i.
- `req_rs2_i` input NUM_REQ*DATA_WIDTH: packed rs2 operands.
- `req_op_i` input NUM_REQ*4: packed 4-bit ALU op codes (salu encoding, ADD=0000 … BGEU=1111).
- `req_lock_i` input NUM_REQ: request to keep the grant after this op; used only with `SALU_ARB_LOCK_EN`.
- `rsp_valid_o` output NUM_REQ: one-hot response valid, routed to the originating requester.
- `rsp_ready_i` input NUM_REQ: per-requester response accept.
- `rsp_data_o` output DATA_WIDTH: result (shared bus, qualified by `rsp_valid_o`).
- `rsp_zero_o`, `rsp_neg_o`, `rsp_ovf_o` output 1 each: ALU zero/branch-taken, negative and overflow flags.
- `alu_rs1_o`, `alu_rs2_o` output DATA_WIDTH: operands to the shared salu.
- `alu_op_o` output 4: op code to the shared salu.
- `alu_res_i` input DATA_WIDTH: result from the salu.
- `alu_zero_i`, `alu_neg_i`, `alu_ovf_i` input 1 each: flags from the salu.
- `busy_o` output 1: any operation in flight (S1 or S2 valid).

## Operation
- Pipeline stage S1 is the operand register: `s1_valid`, id, rs1, rs2, op. It drives `alu_*_o` directly.
- Pipeline stage S2 is the response register: `s2_valid`, id, data, zero, neg, ovf.
- Advance rules:
  - S2 frees when `rsp_valid_o[s2_id] & rsp_ready_i[s2_id]`.
  - S1 moves to S2 when S2 is empty or freeing.
  - S1 may accept when S1 is empty or moving.
- Arbitration:
  - The round-robin pointer `ptr` is 0 at reset.
  - The grant goes to the first valid requester at or after `ptr`, modulo NUM_REQ.
  - `req_ready_o[g]=1` only if S1 may accept.
  - On accept, `ptr ← g+1` modulo NUM_REQ.
- `req_ready_o` is combinational from `req_valid_i`, `ptr`, lock state and stage occupancy.
- Requesters hold valid and payload stable until ready. A requester must not drop valid before ready.
- Flags are passed through from the salu unchanged. The arbiter never interprets op codes.
- Lock FSM, active only with the macro:
  - IDLE → LOCKED(owner=g) on accept with `req_lock_i[g]=1`.
  - LOCKED → IDLE on accept from the owner with `req_lock_i=0`.
  - While LOCKED, only the owner is eligible and `ptr` is frozen.
- Reset, including mid-operation: `s1_valid=s2_valid=0`, `ptr=0`, lock=IDLE. In-flight operations are dropped silently.

## Timing
- Reset values: `req_ready_o=0`, `rsp_valid_o=0`, `rsp_data_o=0`, all flags 0, `alu_*_o=0`, `busy_o=0`.
- Latency: accept on edge N, so the ALU is driven during cycle N+1 and `rsp_valid_o` is high from cycle N+2.
- Throughput is one op/cycle when responses are accepted immediately.
- Under backpressure, up to 2 ops are buffered (S1+S2). With both stages full and S2 stalled, all `req_ready_o=0`.
- On simultaneous S2 drain and new accept, both occur in the same cycle with no bubble.
- The S2 response is held stable while stalled.

## Configuration
- `SALU_ARB_LOCK_EN` defined: the lock FSM is present and `req_lock_i` is honoured.
- Undefined: `req_lock_i` is ignored, the FSM is compiled out, and pure round-robin applies.

## Test plan
- Single ADD: req0 sends ADD 5+7 with `rsp_ready=1111`. Accept at cycle 0; `rsp_valid_o=0001` at cycle 2 with data 12, zero=0.
- Contention: all four requesters valid continuously. Grants go 0,1,2,3,0 on consecutive cycles and each response is routed to its own bit.
- Backpressure: req1 sends SUB 3-3 with `rsp_ready_i[1]=0`. Data 0 and zero=1 are held; a second op fills S1; `req_ready_o=0`. Releasing the stall drains both in order, no loss.
- Overflow: ADD 0x7FFFFFFF+1 returns data 0x80000000, ovf=1, neg=1.
- Lock: req2 sends 3 ops with lock=1,1,0 while req0 is valid. With the macro, grants are 2,2,2,0; without it, grants are 2,0,2,0.
- Reset while S2 is valid: `rsp_valid_o=0` the next cycle and `busy_o=0`. The next accept after reset starts the round-robin search at requester 0.
